hs_dcr_mport: RTL and testbench

- Next-generation DCR register interface for the SATA host block. It serves C_NUM_PORTS SATA ports from one shared register bus.
- Each port gets a W1C interrupt status register, an interrupt enable mask, a DMA command queue of C_DMA_DEPTH entries with a req/ack handshake, and a DMA completion counter.
- It sits between the processor DCR bus and the per-port link/DMA engines, all in the sys_clk domain.

---
 rtl/hs_dcr_mport.sv | 155 +++++++++++++++
 tb/tb_hs_dcr_mport.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_dcr_mport.sv
// Multi-port DCR register block for the SATA host: per-port W1C interrupt status,
// enable masks, DMA command queues with req/ack heads, and DMA completion counters.
module hs_dcr_mport #(
  parameter int C_NUM_PORTS = 2,
  parameter int C_DMA_DEPTH = 4,
  parameter int C_CNT_W     = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [7:0]               address,
  input  logic                     write,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic                     irq,
  input  logic [C_NUM_PORTS-1:0]   linkup,
  input  logic [C_NUM_PORTS-1:0]   plllock,
  input  logic [C_NUM_PORTS-1:0]   rxfifo_irq,
  input  logic [C_NUM_PORTS-1:0]   cxfifo_irq,
  output logic [C_NUM_PORTS-1:0]   dma_req,
  input  logic [C_NUM_PORTS-1:0]   dma_ack,
  output logic [32*C_NUM_PORTS-1:0] dma_address,
  output logic [16*C_NUM_PORTS-1:0] dma_length,
  output logic [4*C_NUM_PORTS-1:0]  dma_pm,
  output logic [4*C_NUM_PORTS-1:0]  dma_flags
);
  localparam int PTR_W = $clog2(C_DMA_DEPTH);
  localparam int QCNT_W = PTR_W + 1;
  localparam logic [QCNT_W-1:0] Q_FULL = QCNT_W'(C_DMA_DEPTH);

  localparam logic [3:0] OFF_STATUS = 4'd0;
  localparam logic [3:0] OFF_ISR    = 4'd1;
  localparam logic [3:0] OFF_IER    = 4'd2;
  localparam logic [3:0] OFF_ADDR   = 4'd3;
  localparam logic [3:0] OFF_CTRL   = 4'd4;
  localparam logic [3:0] OFF_DONE   = 4'd5;

  logic [2:0]         link_sync  [C_NUM_PORTS];
  logic [2:0]         pll_sync   [C_NUM_PORTS];
  logic [1:0]         isr_lo     [C_NUM_PORTS];
  logic [1:0]         isr_hi     [C_NUM_PORTS];
  logic [5:0]         ier_q      [C_NUM_PORTS];
  logic [31:0]        stage_addr [C_NUM_PORTS];
  logic [C_CNT_W-1:0] done_cnt   [C_NUM_PORTS];
  logic [PTR_W-1:0]   wr_ptr     [C_NUM_PORTS];
  logic [PTR_W-1:0]   rd_ptr     [C_NUM_PORTS];
  logic [QCNT_W-1:0]  q_cnt      [C_NUM_PORTS];
  logic [31:0]        q_addr     [C_NUM_PORTS][C_DMA_DEPTH];
  logic [23:0]        q_ctrl     [C_NUM_PORTS][C_DMA_DEPTH];

  logic [C_NUM_PORTS-1:0] port_wr, q_empty, q_full, pop, push, push_ok, pend;
  logic [5:0]             isr_view [C_NUM_PORTS];
  logic [31:0]            rd_mux;
  logic [3:0]             offset;

  assign offset = address[3:0];

  always_comb begin
    dma_address = '0;
    dma_length  = '0;
    dma_pm      = '0;
    dma_flags   = '0;
    for (int p = 0; p < C_NUM_PORTS; p++) begin
      port_wr[p] = write && (address[7:4] == 4'(p));
      q_empty[p] = (q_cnt[p] == '0);
      q_full[p]  = (q_cnt[p] == Q_FULL);
      pop[p]     = dma_ack[p] && !q_empty[p];
      push[p]    = port_wr[p] && (offset == OFF_CTRL);
      // A full queue still accepts a push when the head leaves in the same cycle
      push_ok[p] = push[p] && (!q_full[p] || pop[p]);
      isr_view[p] = {isr_hi[p], cxfifo_irq[p], rxfifo_irq[p], isr_lo[p]};
      pend[p]     = |(isr_view[p] & ier_q[p]);
      dma_req[p]  = !q_empty[p];
      dma_address[32*p +: 32] = q_addr[p][rd_ptr[p]];
      dma_length[16*p +: 16]  = q_ctrl[p][rd_ptr[p]][15:0];
      dma_pm[4*p +: 4]        = q_ctrl[p][rd_ptr[p]][19:16];
      dma_flags[4*p +: 4]     = q_ctrl[p][rd_ptr[p]][23:20];
    end
  end

  always_comb begin
    rd_mux = '0;
    if (address == 8'hFF) begin
      for (int p = 0; p < C_NUM_PORTS; p++) rd_mux[p] = pend[p];
    end else begin
      for (int p = 0; p < C_NUM_PORTS; p++) begin
        if (address[7:4] == 4'(p)) begin
          case (offset)
            OFF_STATUS: begin
              rd_mux[0]     = link_sync[p][1];
              rd_mux[1]     = pll_sync[p][1];
              rd_mux[2]     = rxfifo_irq[p];
              rd_mux[3]     = cxfifo_irq[p];
              rd_mux[8]     = q_empty[p];
              rd_mux[9]     = q_full[p];
              rd_mux[15:12] = 4'(q_cnt[p]);
            end
            OFF_ISR:  rd_mux = {26'b0, isr_view[p]};
            OFF_IER:  rd_mux = {26'b0, ier_q[p]};
            OFF_ADDR: rd_mux = stage_addr[p];
            OFF_DONE: rd_mux = 32'(done_cnt[p]);
            default:  rd_mux = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      readdata <= '0;
      irq      <= 1'b0;
      for (int p = 0; p < C_NUM_PORTS; p++) begin
        link_sync[p]  <= '0;
        pll_sync[p]   <= '0;
        isr_lo[p]     <= '0;
        isr_hi[p]     <= '0;
        ier_q[p]      <= '0;
        stage_addr[p] <= '0;
        done_cnt[p]   <= '0;
        wr_ptr[p]     <= '0;
        rd_ptr[p]     <= '0;
        q_cnt[p]      <= '0;
        for (int e = 0; e < C_DMA_DEPTH; e++) begin
          q_addr[p][e] <= '0;
          q_ctrl[p][e] <= '0;
        end
      end
    end else begin
      readdata <= rd_mux;
      irq      <= |pend;
      for (int p = 0; p < C_NUM_PORTS; p++) begin
        link_sync[p] <= {link_sync[p][1:0], linkup[p]};
        pll_sync[p]  <= {pll_sync[p][1:0], plllock[p]};
        // Hardware set is OR-ed in after the W1C mask so a coincident set survives
        isr_lo[p] <= (isr_lo[p] & ~((port_wr[p] && offset == OFF_ISR) ? writedata[1:0] : 2'b00))
                   | {pll_sync[p][1] ^ pll_sync[p][2], link_sync[p][1] ^ link_sync[p][2]};
        isr_hi[p] <= (isr_hi[p] & ~((port_wr[p] && offset == OFF_ISR) ? writedata[5:4] : 2'b00))
                   | {push[p] && !push_ok[p], pop[p]};
        if (port_wr[p] && offset == OFF_IER)  ier_q[p]      <= writedata[5:0];
        if (port_wr[p] && offset == OFF_ADDR) stage_addr[p] <= writedata;
        if (push_ok[p]) begin
          q_addr[p][wr_ptr[p]] <= stage_addr[p];
          q_ctrl[p][wr_ptr[p]] <= writedata[23:0];
          wr_ptr[p]            <= wr_ptr[p] + PTR_W'(1);
        end
        if (pop[p]) rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
        q_cnt[p] <= q_cnt[p] + QCNT_W'(push_ok[p]) - QCNT_W'(pop[p]);
        if (port_wr[p] && offset == OFF_DONE)
          done_cnt[p] <= pop[p] ? C_CNT_W'(1) : '0;
        else if (pop[p])
          done_cnt[p] <= done_cnt[p] + C_CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_hs_dcr_mport.sv
// Scoreboard bench for hs_dcr_mport: a queue-based per-port model predicts every
// registered output; a negedge monitor pops and compares the predictions.
`timescale 1ns/1ps
module tb_hs_dcr_mport;
  localparam int NP    = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic [7:0]       address;
  logic             write;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic             irq;
  logic [NP-1:0]    linkup, plllock, rxfifo_irq, cxfifo_irq, dma_req, dma_ack;
  logic [32*NP-1:0] dma_address;
  logic [16*NP-1:0] dma_length;
  logic [4*NP-1:0]  dma_pm, dma_flags;

  hs_dcr_mport #(.C_NUM_PORTS(NP), .C_DMA_DEPTH(DEPTH), .C_CNT_W(CNT_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .address(address), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq), .linkup(linkup),
    .plllock(plllock), .rxfifo_irq(rxfifo_irq), .cxfifo_irq(cxfifo_irq),
    .dma_req(dma_req), .dma_ack(dma_ack), .dma_address(dma_address),
    .dma_length(dma_length), .dma_pm(dma_pm), .dma_flags(dma_flags)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct { int due; int kind; int port; logic [31:0] exp; } exp_t;
  exp_t exq[$];
  int checks = 0;
  int errors = 0;

  // Reference model: one FIFO of {addr, ctrl} per port plus plain register values
  logic [55:0]      mq [NP][$];
  logic [5:0]       m_isr   [NP];
  logic [5:0]       m_ier   [NP];
  logic [31:0]      m_stage [NP];
  logic [CNT_W-1:0] m_done  [NP];
  logic [NP-1:0]    lk_h [3];
  logic [NP-1:0]    pl_h [3];
  logic [3:0]       offs [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd15};

  function automatic string kname(int k);
    case (k)
      0: return "readdata";
      1: return "irq";
      2: return "dma_req";
      3: return "dma_address";
      4: return "dma_length";
      5: return "dma_pm";
      default: return "dma_flags";
    endcase
  endfunction

  function automatic logic [31:0] actual(int k, int p);
    case (k)
      0: return readdata;
      1: return {31'b0, irq};
      2: return {{(32-NP){1'b0}}, dma_req};
      3: return dma_address[32*p +: 32];
      4: return {16'b0, dma_length[16*p +: 16]};
      5: return {28'b0, dma_pm[4*p +: 4]};
      default: return {28'b0, dma_flags[4*p +: 4]};
    endcase
  endfunction

  always @(negedge sys_clk) begin
    while (exq.size() > 0 && exq[0].due <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e = exq.pop_front();
      act = actual(e.kind, e.port);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s port%0d cyc%0d: got 0x%08h, expected 0x%08h",
                 kname(e.kind), e.port, cyc, act, e.exp);
      end
    end
  end

  function automatic logic [5:0] isr_view(int p);
    return (m_isr[p] & 6'h33) | {2'b00, cxfifo_irq[p], rxfifo_irq[p], 2'b00};
  endfunction

  function automatic logic pend(int p);
    return |(isr_view(p) & m_ier[p]);
  endfunction

  function automatic logic [31:0] model_read(logic [7:0] a);
    logic [31:0] r;
    int idx;
    r = '0;
    idx = int'(a[7:4]);
    if (a == 8'hFF) begin
      for (int p = 0; p < NP; p++) r[p] = pend(p);
    end else if (idx < NP) begin
      case (a[3:0])
        4'd0: begin
          r[0] = lk_h[1][idx];
          r[1] = pl_h[1][idx];
          r[2] = rxfifo_irq[idx];
          r[3] = cxfifo_irq[idx];
          r[8] = (mq[idx].size() == 0);
          r[9] = (mq[idx].size() == DEPTH);
          r[15:12] = 4'(mq[idx].size());
        end
        4'd1: r = {26'b0, isr_view(idx)};
        4'd2: r = {26'b0, m_ier[idx]};
        4'd3: r = m_stage[idx];
        4'd5: r = 32'(m_done[idx]);
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // One clock: drive inputs, predict the registered outputs, update the model, advance
  task automatic step(input logic rst, input logic [7:0] a, input logic w,
                      input logic [31:0] d, input logic [NP-1:0] ack);
    logic [31:0] rd_e;
    logic        irq_e;
    sys_rst = rst; address = a; write = w; writedata = d; dma_ack = ack;
    rd_e  = rst ? 32'h0 : model_read(a);
    irq_e = 1'b0;
    if (!rst) for (int p = 0; p < NP; p++) irq_e |= pend(p);
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        mq[p].delete();
        m_isr[p] = '0; m_ier[p] = '0; m_stage[p] = '0; m_done[p] = '0;
      end
      for (int i = 0; i < 3; i++) begin lk_h[i] = '0; pl_h[i] = '0; end
    end else begin
      for (int p = 0; p < NP; p++) begin
        logic sel, full, pop_e, push_e;
        logic [5:0] set, clr;
        sel    = w && (int'(a[7:4]) == p);
        full   = (mq[p].size() == DEPTH);
        pop_e  = ack[p] && (mq[p].size() > 0);
        push_e = sel && (a[3:0] == 4'd4);
        set = '0;
        set[0] = (lk_h[1][p] != lk_h[2][p]);
        set[1] = (pl_h[1][p] != pl_h[2][p]);
        set[4] = pop_e;
        set[5] = push_e && full && !pop_e;
        clr = (sel && a[3:0] == 4'd1) ? d[5:0] : 6'h0;
        m_isr[p] = ((m_isr[p] & ~clr) | set) & 6'h33;
        if (sel && a[3:0] == 4'd2) m_ier[p] = d[5:0];
        if (pop_e) void'(mq[p].pop_front());
        if (push_e && (!full || pop_e)) mq[p].push_back({m_stage[p], d[23:0]});
        if (sel && a[3:0] == 4'd3) m_stage[p] = d;
        if (sel && a[3:0] == 4'd5) m_done[p] = pop_e ? CNT_W'(1) : '0;
        else if (pop_e) m_done[p] = m_done[p] + CNT_W'(1);
      end
      lk_h[2] = lk_h[1]; lk_h[1] = lk_h[0]; lk_h[0] = linkup;
      pl_h[2] = pl_h[1]; pl_h[1] = pl_h[0]; pl_h[0] = plllock;
    end
    exq.push_back('{due: cyc + 1, kind: 0, port: 0, exp: rd_e});
    exq.push_back('{due: cyc + 1, kind: 1, port: 0, exp: {31'b0, irq_e}});
    begin
      logic [31:0] req_e;
      req_e = '0;
      for (int p = 0; p < NP; p++) req_e[p] = (mq[p].size() > 0);
      exq.push_back('{due: cyc + 1, kind: 2, port: 0, exp: req_e});
    end
    for (int p = 0; p < NP; p++) begin
      if (mq[p].size() > 0) begin
        exq.push_back('{due: cyc + 1, kind: 3, port: p, exp: mq[p][0][55:24]});
        exq.push_back('{due: cyc + 1, kind: 4, port: p, exp: {16'b0, mq[p][0][15:0]}});
        exq.push_back('{due: cyc + 1, kind: 5, port: p, exp: {28'b0, mq[p][0][19:16]}});
        exq.push_back('{due: cyc + 1, kind: 6, port: p, exp: {28'b0, mq[p][0][23:20]}});
      end
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a);
    step(1'b0, a, 1'b0, 32'h0, '0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    step(1'b0, a, 1'b1, d, '0);
  endtask

  task automatic ackp(input logic [NP-1:0] m, input logic [7:0] a);
    step(1'b0, a, 1'b0, 32'h0, m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    linkup = '0; plllock = '0; rxfifo_irq = '0; cxfifo_irq = '0;
    sys_rst = 1'b1; address = '0; write = 1'b0; writedata = '0; dma_ack = '0;
    step(1'b1, 8'h00, 1'b0, 32'h0, '0);
    step(1'b1, 8'h00, 1'b0, 32'h0, '0);
    rd(8'h10); rd(8'h11); rd(8'h10);

    // Single entry through port 0, completion interrupt and its clear
    wr(8'h03, 32'h1000_0000);
    wr(8'h04, 32'h0030_0200);
    wr(8'h02, 32'h0000_0010);
    ackp(2'b01, 8'h05);
    rd(8'h05); rd(8'h01); rd(8'h01);
    wr(8'h01, 32'h0000_0010);
    rd(8'h01); rd(8'h01);

    // Overflow port 1 with five random entries, then drain in order
    for (int i = 0; i < 5; i++) begin
      wr(8'h13, $urandom);
      wr(8'h14, $urandom);
    end
    rd(8'h10); rd(8'h11);
    for (int i = 0; i < 4; i++) ackp(2'b10, 8'h10);
    wr(8'h11, 32'h0000_003F);

    // Full queue with a same-cycle push and ack
    for (int i = 0; i < 4; i++) begin
      wr(8'h13, $urandom);
      wr(8'h14, $urandom);
    end
    wr(8'h13, $urandom);
    step(1'b0, 8'h14, 1'b1, $urandom, 2'b10);
    rd(8'h10); rd(8'h11);
    for (int i = 0; i < 4; i++) ackp(2'b10, 8'h10);

    // Link change detection, then a W1C landing on the second change
    linkup[1] = 1'b1;
    rd(8'h11); rd(8'h11); rd(8'h11); rd(8'h10);
    linkup[1] = 1'b0;
    rd(8'h11); rd(8'h11);
    wr(8'h11, 32'h0000_0001);
    rd(8'h11); rd(8'h11);
    wr(8'h11, 32'h0000_0001);
    rd(8'h11);

    // Live level interrupts and the global summary register
    wr(8'h02, 32'h0000_000C);
    rxfifo_irq[0] = 1'b1;
    rd(8'h01); rd(8'hFF); rd(8'hFF);
    rxfifo_irq[0] = 1'b0; cxfifo_irq[0] = 1'b1;
    rd(8'h00); rd(8'hFF);
    cxfifo_irq[0] = 1'b0;
    rd(8'hFF);

    // Port index beyond the implemented ports
    wr(8'h32, 32'h0000_003F);
    wr(8'h33, 32'hDEAD_BEEF);
    wr(8'h34, 32'h00FF_FFFF);
    rd(8'h32); rd(8'h33); rd(8'h30); rd(8'hF0);

    // Randomized traffic across ports, offsets, acks and input levels
    for (int i = 0; i < 400; i++) begin
      logic [3:0] pi;
      logic [7:0] a;
      logic       w;
      logic [NP-1:0] ak;
      case ($urandom_range(0, 5))
        0, 1:    pi = 4'd0;
        2, 3:    pi = 4'd1;
        4:       pi = 4'd3;
        default: pi = 4'd15;
      endcase
      a  = {pi, offs[$urandom_range(0, 7)]};
      w  = ($urandom_range(0, 1) == 1);
      ak = ($urandom_range(0, 2) == 0) ? NP'($urandom) : '0;
      if ($urandom_range(0, 9) == 0) linkup     ^= NP'($urandom);
      if ($urandom_range(0, 9) == 0) plllock    ^= NP'($urandom);
      if ($urandom_range(0, 7) == 0) rxfifo_irq  = NP'($urandom);
      if ($urandom_range(0, 7) == 0) cxfifo_irq  = NP'($urandom);
      step(1'b0, a, w, $urandom, ak);
    end

    // Reset while port 0 holds work
    rxfifo_irq = '0; cxfifo_irq = '0;
    wr(8'h03, 32'h2000_0040);
    wr(8'h04, 32'h0010_0100);
    ackp(2'b01, 8'h00);
    wr(8'h04, 32'h0020_0080);
    step(1'b1, 8'h05, 1'b0, 32'h0, '0);
    rd(8'h05); rd(8'h00); rd(8'h01);

    @(negedge sys_clk);
    #1;
    if (exq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
